aclk_time_setter: RTL

- Upstream stage of the alarm clock core: converts three raw push-buttons into HH:MM entry.
- Drives the core's H_in1/H_in0/M_in1/M_in0 digits and issues a single-cycle LD_time or LD_alarm pulse only after a complete, valid entry.
- Runs on the same 10 Hz clock as the core; all outputs are registered.

---
 rtl/aclk_set_pkg.sv | 28 ++
 rtl/aclk_btn_debounce.sv | 25 ++
 rtl/aclk_time_setter.sv | 104 ++++++++++
 3 files changed

// File: rtl/aclk_set_pkg.sv
// aclk_set_pkg: shared types and digit limits for the alarm-clock time setter
package aclk_set_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EDIT_H1 = 3'd1,
    EDIT_H0 = 3'd2,
    EDIT_M1 = 3'd3,
    EDIT_M0 = 3'd4,
    COMMIT  = 3'd5
  } set_state_e;
  typedef enum logic [1:0] {
    DIG_H1 = 2'd0,
    DIG_H0 = 2'd1,
    DIG_M1 = 2'd2,
    DIG_M0 = 2'd3
  } digit_e;
  localparam logic [1:0] H1_MAX     = 2'd2;
  localparam logic [3:0] H0_MAX     = 4'd9;
  localparam logic [3:0] H0_MAX_H20 = 4'd3;
  localparam logic [3:0] M1_MAX     = 4'd5;
  localparam logic [3:0] M0_MAX     = 4'd9;
  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } hhmm_t;
endpackage

// File: rtl/aclk_btn_debounce.sv
// aclk_btn_debounce: 2-FF synchroniser, DB_CYCLES debouncer and rising-edge press pulse
// Ports: clk, reset_n (async active-low), btn (raw) -> level (debounced), press (1-cycle pulse)
module aclk_btn_debounce #(
  parameter int DB_CYCLES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic s1, s2, flip;
  logic [CW-1:0] cnt;
  assign flip = (s2 != level) && cnt == CW'(DB_CYCLES - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {s1, s2, cnt, level, press} <= '0;
    else begin
      s1    <= btn;
      s2    <= s1;
      cnt   <= (s2 == level || flip) ? '0 : cnt + CW'(1);
      level <= flip ? s2 : level;
      press <= flip && s2;
    end
endmodule

// File: rtl/aclk_time_setter.sv
// aclk_time_setter: turns set/inc/alarm push-buttons into validated HH:MM entry with LD pulses
// Ports: clk, reset_n (async active-low); btn_set, btn_inc, btn_alarm (raw buttons);
//        H_in1/H_in0/M_in1/M_in0 (digits), LD_time/LD_alarm (1-cycle loads), editing, edit_digit.
// Optional: `define ACLK_SET_AUTO_REPEAT_EN enables auto-repeat while btn_inc is held.
import aclk_set_pkg::*;
module aclk_time_setter #(
  parameter int DB_CYCLES      = 3,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int REPEAT_DELAY   = 10,
  parameter int REPEAT_RATE    = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_alarm,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       editing,
  output logic [1:0] edit_digit
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic set_p, set_lvl, inc_p, inc_lvl, alarm_lvl, alarm_p;
  logic edit_st, inc_ev, inc_do, tmo, tgt, unused_sink;
  logic [1:0] h1_n;
  logic [3:0] h0_max;
  logic [TW-1:0] to_cnt;
  set_state_e st, st_n;
  hhmm_t w, w_n, sh;
  aclk_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_set (
    .clk(clk), .reset_n(reset_n), .btn(btn_set), .level(set_lvl), .press(set_p));
  aclk_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_inc (
    .clk(clk), .reset_n(reset_n), .btn(btn_inc), .level(inc_lvl), .press(inc_p));
  aclk_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_alarm (
    .clk(clk), .reset_n(reset_n), .btn(btn_alarm), .level(alarm_lvl), .press(alarm_p));
  assign edit_st = st inside {EDIT_H1, EDIT_H0, EDIT_M1, EDIT_M0};
`ifdef ACLK_SET_AUTO_REPEAT_EN
  // rep_cnt restarts on each press; after the first repeat it is rewound so later repeats
  // come every REPEAT_RATE cycles
  logic [7:0] rep_cnt;
  logic rep;
  assign rep = edit_st && inc_lvl && !inc_p && rep_cnt == 8'(REPEAT_DELAY - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rep_cnt <= '0;
    else rep_cnt <= (inc_p || !inc_lvl || !edit_st) ? '0 : rep ? 8'(REPEAT_DELAY - REPEAT_RATE) : rep_cnt + 8'd1;
  assign inc_ev = inc_p | rep;
  assign unused_sink = ^{set_lvl, alarm_p};
`else
  assign inc_ev = inc_p;
  assign unused_sink = ^{set_lvl, alarm_p, inc_lvl, REPEAT_DELAY > REPEAT_RATE};
`endif
  // set wins over a coincident increment
  assign inc_do = inc_ev && !set_p && edit_st;
  assign tmo = edit_st && !set_p && !inc_ev && to_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    st_n = st;
    if (st == COMMIT || tmo) st_n = IDLE;
    else if (set_p) st_n = st == IDLE ? EDIT_H1 : st == EDIT_H1 ? EDIT_H0 : st == EDIT_H0 ? EDIT_M1 : st == EDIT_M1 ? EDIT_M0 : COMMIT;
  end
  always_comb begin
    h1_n = (w.h1 == H1_MAX) ? 2'd0 : w.h1 + 2'd1;
    h0_max = (w.h1 == H1_MAX) ? H0_MAX_H20 : H0_MAX;
    w_n = w;
    if (tmo) w_n = sh;
    else if (inc_do) begin
      w_n.h1 = st == EDIT_H1 ? h1_n : w.h1;
      // moving into the 20s pulls an out-of-range hour digit down to 3
      w_n.h0 = st == EDIT_H0 ? (w.h0 >= h0_max ? 4'd0 : w.h0 + 4'd1)
             : st == EDIT_H1 && h1_n == H1_MAX && w.h0 > H0_MAX_H20 ? H0_MAX_H20 : w.h0;
      w_n.m1 = st == EDIT_M1 ? (w.m1 >= M1_MAX ? 4'd0 : w.m1 + 4'd1) : w.m1;
      w_n.m0 = st == EDIT_M0 ? (w.m0 >= M0_MAX ? 4'd0 : w.m0 + 4'd1) : w.m0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st         <= IDLE;
      w          <= '0;
      sh         <= '0;
      tgt        <= 1'b0;
      to_cnt     <= '0;
      LD_time    <= 1'b0;
      LD_alarm   <= 1'b0;
      editing    <= 1'b0;
      edit_digit <= 2'd0;
    end else begin
      st         <= st_n;
      w          <= w_n;
      tgt        <= (st == IDLE && set_p) ? alarm_lvl : tgt;
      sh         <= st_n == COMMIT ? w_n : sh;
      to_cnt     <= (!edit_st || set_p || inc_ev || tmo) ? '0 : to_cnt + TW'(1);
      LD_time    <= st_n == COMMIT && !tgt;
      LD_alarm   <= st_n == COMMIT && tgt;
      editing    <= st_n inside {EDIT_H1, EDIT_H0, EDIT_M1, EDIT_M0};
      edit_digit <= st_n == EDIT_H0 ? DIG_H0 : st_n == EDIT_M1 ? DIG_M1 : st_n == EDIT_M0 ? DIG_M0 : DIG_H1;
    end
  assign H_in1 = w.h1;
  assign H_in0 = w.h0;
  assign M_in1 = w.m1;
  assign M_in0 = w.m0;
endmodule
